alaw_coder_sched: RTL and testbench

Round-robin scheduler that shares one `alaw_coder` instance among `CH_N` sample producers. It accepts one linear sample at a time from the requesting channels and issues it to the coder as a single-cycle `valid_in` pulse. It then waits for the coder's `valid_out` and returns the 8-bit code to the originating channel. It sits between the per-channel acquisition front ends and the shared companding datapath, and guards against a hung coder with a response timeout.

---
 rtl/alaw_sched_pkg.sv | 18 +
 rtl/alaw_coder_sched_if.sv | 19 +
 rtl/alaw_coder_sched_rr_arbiter.sv | 33 +++
 rtl/alaw_coder_sched.sv | 113 +++++++++++
 tb/tb_alaw_coder_sched.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alaw_sched_pkg.sv
// Shared types and helpers for the A-law coder round-robin scheduler.
package alaw_sched_pkg;

  localparam int CH_N_DEFAULT = 4;

  function automatic int clog2(input int n);
    int r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  localparam int CH_W = clog2(CH_N_DEFAULT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} sched_state_e;

endpackage

// File: rtl/alaw_coder_sched_if.sv
// Channel-side bundle: per-channel sample requests in, per-channel coded results out.
interface alaw_coder_sched_if #(
  parameter int CH_N       = 4,
  parameter int DATA_IN_W  = 15,
  parameter int DATA_OUT_W = 8
);
  import alaw_sched_pkg::*;

  logic [CH_N*DATA_IN_W-1:0] s_data;
  logic [CH_N-1:0]           s_valid;
  logic [CH_N-1:0]           s_ready;
  logic [DATA_OUT_W-1:0]     m_data;
  logic [CH_N-1:0]           m_valid;
  logic [clog2(CH_N)-1:0]    m_ch;

  modport master (output s_data, s_valid, input s_ready, m_data, m_valid, m_ch);
  modport slave  (input s_data, s_valid, output s_ready, m_data, m_valid, m_ch);

endinterface

// File: rtl/alaw_coder_sched_rr_arbiter.sv
// Combinational round-robin arbiter: searches from last+1 upward, wrapping.
module rr_arbiter
  import alaw_sched_pkg::*;
#(
  parameter int  CH_N = CH_N_DEFAULT,
  localparam int IW   = clog2(CH_N)
) (
  input  logic [CH_N-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [CH_N-1:0] gnt,
  output logic [IW-1:0]   gnt_idx,
  output logic            any
);

  int idx;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int i = 1; i <= CH_N; i++) begin
      idx = (int'(last) + i) % CH_N;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/alaw_coder_sched.sv
// Shares one alaw_coder among CH_N producers: one request in flight, round-robin grant,
// rising-edge response capture and a response timeout.
module alaw_coder_sched
  import alaw_sched_pkg::*;
#(
  parameter int  CH_N       = CH_N_DEFAULT,
  parameter int  DATA_IN_W  = 15,
  parameter int  DATA_OUT_W = 8,
  parameter int  TIMEOUT    = 64,
  localparam int IW         = clog2(CH_N),
  localparam int CNT_W      = clog2(TIMEOUT)
) (
  input  logic                  clk,
  input  logic                  rst,
  alaw_coder_sched_if.slave     chan,
  output logic [DATA_IN_W-1:0]  cdr_data_in,
  output logic                  cdr_valid_in,
  input  logic [DATA_OUT_W-1:0] cdr_data_out,
  input  logic                  cdr_valid_out,
  output logic                  busy,
  output logic                  timeout_err
);

  sched_state_e          state_q, state_d;
  logic [IW-1:0]         last_q, m_ch_q, gnt_idx;
  logic [CH_N-1:0]       gnt, ready, m_valid;
  logic                  any, vo_q, vo_edge;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_IN_W-1:0]  data_in_q;
  logic [DATA_OUT_W-1:0] m_data_q;

  rr_arbiter #(.CH_N(CH_N)) u_arb (
    .req     (chan.s_valid),
    .last    (last_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  // Only a fresh rising edge counts; a level left over from an earlier conversion is stale.
  assign vo_edge = cdr_valid_out & ~vo_q;

  always_comb begin
    state_d      = state_q;
    ready        = '0;
    m_valid      = '0;
    cdr_valid_in = 1'b0;
    timeout_err  = 1'b0;
    busy         = (state_q != IDLE);
    case (state_q)
      IDLE: if (any) begin
        state_d = ISSUE;
        ready   = rst ? '0 : gnt;
      end
      ISSUE: begin
        cdr_valid_in = 1'b1;
        state_d      = WAIT;
      end
      WAIT: begin
        // The edge is tested first so it wins over a simultaneous terminal count.
        if (vo_edge) begin
          state_d = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          timeout_err = 1'b1;
          state_d     = IDLE;
        end
      end
      RESP: begin
        m_valid = CH_N'(1) << m_ch_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= IW'(CH_N - 1);
      vo_q      <= 1'b0;
      cnt_q     <= '0;
      data_in_q <= '0;
      m_data_q  <= '0;
      m_ch_q    <= '0;
    end else begin
      state_q <= state_d;
      vo_q    <= cdr_valid_out;
      case (state_q)
        IDLE: if (any) begin
          data_in_q <= chan.s_data[int'(gnt_idx)*DATA_IN_W +: DATA_IN_W];
          last_q    <= gnt_idx;
        end
        ISSUE: cnt_q <= '0;
        WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (vo_edge) begin
            m_data_q <= cdr_data_out;
            m_ch_q   <= last_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign chan.s_ready = ready;
  assign chan.m_data  = m_data_q;
  assign chan.m_valid = m_valid;
  assign chan.m_ch    = m_ch_q;
  assign cdr_data_in  = data_in_q;

endmodule

// File: tb/tb_alaw_coder_sched.sv
// Directed bench for alaw_coder_sched with a 3-cycle coder model returning data_in[14:7].
module tb_alaw_coder_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] cdr_data_in;
  logic        cdr_valid_in;
  logic [7:0]  cdr_data_out = '0;
  logic        cdr_valid_out;
  logic        busy, timeout_err;

  // Coder model controls
  logic        stall = 1'b0, hold = 1'b0, force_vo = 1'b0;
  logic        p0 = 1'b0, p1 = 1'b0;
  logic [14:0] d0 = '0, d1 = '0;
  int          vo_cnt = 0;

  int total = 0;
  int bad   = 0;
  int cycle = 0;

  alaw_coder_sched_if #(.CH_N(4), .DATA_IN_W(15), .DATA_OUT_W(8)) bus ();

  alaw_coder_sched #(.CH_N(4), .DATA_IN_W(15), .DATA_OUT_W(8), .TIMEOUT(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .chan          (bus),
    .cdr_data_in   (cdr_data_in),
    .cdr_valid_in  (cdr_valid_in),
    .cdr_data_out  (cdr_data_out),
    .cdr_valid_out (cdr_valid_out),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  // valid_in sampled at edge E -> valid_out high in the cycle after edge E+2
  always @(posedge clk) begin
    p0 <= cdr_valid_in;
    d0 <= cdr_data_in;
    p1 <= p0;
    d1 <= d0;
    if (p1 && !stall) begin
      vo_cnt       <= hold ? 5 : 1;
      cdr_data_out <= d1[14:7];
    end else if (vo_cnt != 0) begin
      vo_cnt <= vo_cnt - 1;
    end
  end
  assign cdr_valid_out = (vo_cnt != 0) || force_vo;

  task automatic tick();
    @(negedge clk);
    cycle++;
  endtask

  task automatic set_ch(input int k, input logic [14:0] v);
    bus.s_data[k*15 +: 15] = v;
  endtask

  task automatic wait_result(input int budget, output bit got);
    int n = 0;
    got = 1'b0;
    while (n < budget && !got) begin
      tick();
      n++;
      if (bus.m_valid != 4'b0000) got = 1'b1;
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.s_valid = '0;
    bus.s_data  = '0;
    repeat (3) tick();
    total++;
    if ({bus.s_ready, bus.m_data, bus.m_valid, bus.m_ch, cdr_data_in, cdr_valid_in, busy, timeout_err} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got ready=%b data=%h valid=%b ch=%0d din=%h vin=%b busy=%b te=%b, want all 0",
               bus.s_ready, bus.m_data, bus.m_valid, bus.m_ch, cdr_data_in, cdr_valid_in, busy, timeout_err);
    end
    bus.s_valid = 4'hF;
    #1;
    total++;
    if (bus.s_ready !== 4'b0000) begin
      bad++;
      $display("FAIL reset_ready: got %b want 0000", bus.s_ready);
    end
    bus.s_valid = '0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    set_ch(0, 15'h7F80);
    bus.s_valid = 4'b0001;
    #1;
    total++;
    if (bus.s_ready !== 4'b0001) begin
      bad++;
      $display("FAIL single_ready: got %b want 0001", bus.s_ready);
    end
    tick();
    bus.s_valid = '0;
    total++;
    if ({cdr_valid_in, busy, cdr_data_in} !== {1'b1, 1'b1, 15'h7F80}) begin
      bad++;
      $display("FAIL single_issue: got vin=%b busy=%b din=%h want 1 1 7f80", cdr_valid_in, busy, cdr_data_in);
    end
    for (int n = 2; n <= 4; n++) begin
      tick();
      total++;
      if ({bus.m_valid, cdr_valid_in} !== 5'b0) begin
        bad++;
        $display("FAIL single_wait%0d: got m_valid=%b vin=%b want 0 0", n, bus.m_valid, cdr_valid_in);
      end
    end
    tick();
    total++;
    if ({bus.m_valid, bus.m_data, bus.m_ch} !== {4'b0001, 8'hFF, 2'd0}) begin
      bad++;
      $display("FAIL single_resp: got valid=%b data=%h ch=%0d want 0001 ff 0", bus.m_valid, bus.m_data, bus.m_ch);
    end
    tick();
    total++;
    if ({bus.m_valid, busy} !== 5'b0) begin
      bad++;
      $display("FAIL single_after: got valid=%b busy=%b want 0000 0", bus.m_valid, busy);
    end
  endtask

  task automatic test_round_robin();
    bit got;
    int prev = 0;
    pulse_reset();
    for (int k = 0; k < 4; k++) set_ch(k, 15'(k << 7));
    bus.s_valid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      wait_result(20, got);
      total++;
      if (!got) begin
        bad++;
        $display("FAIL rr_timeout%0d: no m_valid within 20 cycles", i);
      end else if ({bus.m_valid, bus.m_ch, bus.m_data} !== {4'(1 << (i % 4)), 2'(i % 4), 8'(i % 4)}) begin
        bad++;
        $display("FAIL rr_result%0d: got valid=%b ch=%0d data=%h want %b %0d %h",
                 i, bus.m_valid, bus.m_ch, bus.m_data, 4'(1 << (i % 4)), i % 4, i % 4);
      end
      if (i > 0) begin
        total++;
        if (cycle - prev !== 6) begin
          bad++;
          $display("FAIL rr_spacing%0d: got %0d cycles want 6", i, cycle - prev);
        end
      end
      prev = cycle;
      if (i == 7) bus.s_valid = '0;
    end
    repeat (2) tick();
  endtask

  task automatic test_timeout();
    int issue_cyc = 0;
    int mv_seen = 0;
    bit found = 1'b0;
    bit te_found = 1'b0;
    bit got;
    pulse_reset();
    stall = 1'b1;
    set_ch(0, 15'h7F80);
    set_ch(1, 15'h1234);
    bus.s_valid = 4'b0011;
    for (int n = 0; n < 10 && !found; n++) begin
      tick();
      if (cdr_valid_in) begin
        found = 1'b1;
        issue_cyc = cycle;
      end
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL to_issue: cdr_valid_in not seen within 10 cycles");
    end
    for (int n = 0; n < 80 && !te_found; n++) begin
      tick();
      if (bus.m_valid != 4'b0000) mv_seen++;
      if (timeout_err) te_found = 1'b1;
    end
    total++;
    if (!te_found) begin
      bad++;
      $display("FAIL to_pulse: timeout_err not seen within 80 cycles");
    end else if (cycle - issue_cyc !== 64) begin
      bad++;
      $display("FAIL to_delay: got %0d cycles after ISSUE want 64", cycle - issue_cyc);
    end
    total++;
    if (mv_seen !== 0) begin
      bad++;
      $display("FAIL to_no_mvalid: got %0d m_valid cycles want 0", mv_seen);
    end
    tick();
    stall = 1'b0;
    total++;
    if ({timeout_err, busy, bus.s_ready} !== {1'b0, 1'b0, 4'b0010}) begin
      bad++;
      $display("FAIL to_next_grant: got te=%b busy=%b ready=%b want 0 0 0010", timeout_err, busy, bus.s_ready);
    end
    tick();
    bus.s_valid = '0;
    wait_result(10, got);
    total++;
    if (!got || {bus.m_valid, bus.m_ch, bus.m_data} !== {4'b0010, 2'd1, 8'h24}) begin
      bad++;
      $display("FAIL to_ch1_result: got seen=%b valid=%b ch=%0d data=%h want 1 0010 1 24",
               got, bus.m_valid, bus.m_ch, bus.m_data);
    end
    repeat (2) tick();
  endtask

  task automatic test_hold();
    int pulses = 0;
    logic [7:0] seen_data = '0;
    logic [1:0] seen_ch = '0;
    hold = 1'b1;
    set_ch(2, 15'h2A80);
    bus.s_valid = 4'b0100;
    tick();
    bus.s_valid = '0;
    for (int n = 0; n < 14; n++) begin
      tick();
      if (bus.m_valid != 4'b0000) begin
        pulses++;
        seen_data = bus.m_data;
        seen_ch   = bus.m_ch;
      end
    end
    hold = 1'b0;
    total++;
    if (pulses !== 1) begin
      bad++;
      $display("FAIL hold_pulses: got %0d m_valid pulses want 1", pulses);
    end
    total++;
    if ({seen_data, seen_ch, busy} !== {8'h55, 2'd2, 1'b0}) begin
      bad++;
      $display("FAIL hold_result: got data=%h ch=%0d busy=%b want 55 2 0", seen_data, seen_ch, busy);
    end
  endtask

  task automatic test_stale();
    int anomalies = 0;
    force_vo = 1'b1;
    tick();
    force_vo = 1'b0;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (bus.m_valid != 4'b0000 || busy) anomalies++;
    end
    total++;
    if (anomalies !== 0) begin
      bad++;
      $display("FAIL stale_ignored: got %0d cycles with m_valid/busy want 0", anomalies);
    end
  endtask

  task automatic test_reset_mid();
    int anomalies = 0;
    bit got;
    set_ch(1, 15'h0380);
    bus.s_valid = 4'b0010;
    tick();
    bus.s_valid = '0;
    tick();
    rst = 1'b1;
    tick();
    total++;
    if ({bus.s_ready, bus.m_data, bus.m_valid, bus.m_ch, cdr_data_in, cdr_valid_in, busy, timeout_err} !== '0) begin
      bad++;
      $display("FAIL midrst_outputs: got ready=%b data=%h valid=%b ch=%0d din=%h vin=%b busy=%b te=%b, want all 0",
               bus.s_ready, bus.m_data, bus.m_valid, bus.m_ch, cdr_data_in, cdr_valid_in, busy, timeout_err);
    end
    rst = 1'b0;
    for (int n = 0; n < 8; n++) begin
      tick();
      if (bus.m_valid != 4'b0000 || timeout_err || busy) anomalies++;
    end
    total++;
    if (anomalies !== 0) begin
      bad++;
      $display("FAIL midrst_late_resp: got %0d active cycles want 0", anomalies);
    end
    for (int k = 0; k < 4; k++) set_ch(k, 15'(k << 7));
    bus.s_valid = 4'hF;
    #1;
    total++;
    if (bus.s_ready !== 4'b0001) begin
      bad++;
      $display("FAIL midrst_first_grant: got %b want 0001", bus.s_ready);
    end
    tick();
    bus.s_valid = '0;
    wait_result(10, got);
    total++;
    if (!got || {bus.m_valid, bus.m_ch} !== {4'b0001, 2'd0}) begin
      bad++;
      $display("FAIL midrst_result: got seen=%b valid=%b ch=%0d want 1 0001 0", got, bus.m_valid, bus.m_ch);
    end
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_hold();
    test_stale();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
